// File: rtl/alu_muldiv_ctrl_if.sv
// Request/response bundle between the main controller and the ALU control / mul-div unit.
interface alu_muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic [3:0]       ALUControl;
    logic             illegal;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hilo_rdata;

    modport master (
        output op_valid, ALUOp, funct, a, b,
        input  ALUControl, illegal, stall, busy, done, div_zero, hi, lo, hilo_rdata
    );

    modport slave (
        input  op_valid, ALUOp, funct, a, b,
        output ALUControl, illegal, stall, busy, done, div_zero, hi, lo, hilo_rdata
    );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus iterative multiply/divide engine with HI/LO registers.
// Optional macro ALU_EARLY_OUT_EN: zero mul operand or zero divisor bypasses iteration.
module alu_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_muldiv_ctrl_if.slave bus
);
    localparam logic [3:0] ALUOP_RTYPE = 4'b1111;
    localparam logic [5:0] F_MTHI      = 6'd17;
    localparam logic [5:0] F_MFHI      = 6'd16;
    localparam logic [5:0] F_MFLO      = 6'd18;
    localparam logic [5:0] F_MTLO      = 6'd19;
    localparam logic [5:0] F_MULT      = 6'd24;
    localparam logic [5:0] F_MULTU     = 6'd25;
    localparam logic [5:0] F_DIV       = 6'd26;
    localparam logic [5:0] F_DIVU      = 6'd27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             is_div_q, is_div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [3:0]         alu_ctrl_c;
    logic               legal_c;
    logic               rtype_c;
    logic               rtype_v_c;
    logic               hilo_class_c;
    logic               signed_op_c;
    logic               start_mul_c;
    logic               start_div_c;
    logic               early_c;
    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_sh_c;
    logic               div_ge_c;
    logic [WIDTH-1:0]   div_sub_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   hilo_rdata_c;

    // ALUOp / funct decode to the 4-bit ALU operation code
    always_comb begin
        alu_ctrl_c = 4'b0000;
        legal_c    = 1'b1;
        if (bus.ALUOp == ALUOP_RTYPE) begin
            case (bus.funct)
                6'd32:        alu_ctrl_c = 4'b0001;
                6'd34:        alu_ctrl_c = 4'b0010;
                6'd36:        alu_ctrl_c = 4'b1010;
                6'd37:        alu_ctrl_c = 4'b1011;
                6'd38:        alu_ctrl_c = 4'b1100;
                6'd39:        alu_ctrl_c = 4'b1101;
                6'd42, 6'd43: alu_ctrl_c = 4'b0111;
                6'd0:         alu_ctrl_c = 4'b0011;
                6'd2:         alu_ctrl_c = 4'b0100;
                6'd3:         alu_ctrl_c = 4'b0110;
                6'd16, 6'd17, 6'd18, 6'd19,
                6'd24, 6'd25, 6'd26, 6'd27: alu_ctrl_c = 4'b0000;
                default:      legal_c = 1'b0;
            endcase
        end else begin
            case (bus.ALUOp)
                4'b0001:                   alu_ctrl_c = 4'b0001;
                4'b0010:                   alu_ctrl_c = 4'b1010;
                4'b0011:                   alu_ctrl_c = 4'b1011;
                4'b0100:                   alu_ctrl_c = 4'b1100;
                4'b0101, 4'b0110:          alu_ctrl_c = 4'b0010;
                4'b0111, 4'b1000:          alu_ctrl_c = 4'b0111;
                4'b1001, 4'b1100, 4'b1101: alu_ctrl_c = 4'b0000;
                4'b1010, 4'b1011:          alu_ctrl_c = 4'b0001;
                default:                   legal_c = 1'b0;
            endcase
        end
    end

    // HI/LO class is funct 16-19 and 24-27: 01x0xx
    assign rtype_c      = (bus.ALUOp == ALUOP_RTYPE);
    assign rtype_v_c    = bus.op_valid & rtype_c;
    assign hilo_class_c = rtype_c & (bus.funct[5:4] == 2'b01) & ~bus.funct[2];
    assign signed_op_c  = ~bus.funct[0];

    assign start_mul_c = rtype_v_c & (state_q == S_IDLE) &
                         ((bus.funct == F_MULT) | (bus.funct == F_MULTU));
    assign start_div_c = rtype_v_c & (state_q == S_IDLE) &
                         ((bus.funct == F_DIV) | (bus.funct == F_DIVU));

    assign mag_a_c = (signed_op_c && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b_c = (signed_op_c && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef ALU_EARLY_OUT_EN
    assign early_c = start_mul_c ? ((bus.a == '0) | (bus.b == '0)) : (bus.b == '0);
`else
    assign early_c = 1'b0;
`endif

    // Shift-add step: {acc, mq} shifts right with the carry-out of the partial sum
    assign mul_sum_c = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dsr_q} : '0);

    // Restoring step: partial remainder shifted left by one dividend bit
    assign div_sh_c  = {acc_q, mq_q[WIDTH-1]};
    assign div_ge_c  = (div_sh_c >= {1'b0, dsr_q});
    assign div_sub_c = div_sh_c[WIDTH-1:0] - dsr_q;

    assign prod_c = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};

    always_comb begin
        hilo_rdata_c = '0;
        if (rtype_v_c && (bus.funct == F_MFHI)) begin
            hilo_rdata_c = hi_q;
        end else if (rtype_v_c && (bus.funct == F_MFLO)) begin
            hilo_rdata_c = lo_q;
        end
    end

    // Engine next-state and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        dsr_d      = dsr_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        is_div_d   = is_div_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_mul_c || start_div_c) begin
                    dsr_d     = mag_b_c;
                    acc_d     = '0;
                    mq_d      = mag_a_c;
                    cnt_d     = CNT_W'(WIDTH);
                    neg_d     = signed_op_c & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_rem_d = signed_op_c & bus.a[WIDTH-1];
                    is_div_d  = start_div_c;
                    dz_d      = start_div_c & (bus.b == '0);
                    busy_d    = 1'b1;
                    state_d   = start_div_c ? S_DIV : S_MUL;
                    // Preload what the full iteration would have left behind
                    if (early_c) begin
                        cnt_d   = '0;
                        state_d = S_FIN;
                        acc_d   = start_div_c ? mag_a_c : '0;
                        mq_d    = start_div_c ? '1 : '0;
                    end
                end else if (rtype_v_c && (bus.funct == F_MTHI)) begin
                    hi_d = bus.a;
                end else if (rtype_v_c && (bus.funct == F_MTLO)) begin
                    lo_d = bus.a;
                end
            end
            S_MUL: begin
                acc_d = mul_sum_c[WIDTH:1];
                mq_d  = {mul_sum_c[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                acc_d = div_ge_c ? div_sub_c : div_sh_c[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], div_ge_c};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                // Zero divisor leaves |a| in acc, so the remainder path already yields hi = a
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (neg_q ? -mq_q : mq_q);
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end else begin
                    hi_d = prod_c[2*WIDTH-1:WIDTH];
                    lo_d = prod_c[WIDTH-1:0];
                end
                done_d     = 1'b1;
                div_zero_d = dz_q;
                busy_d     = 1'b0;
                cnt_d      = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            dsr_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            is_div_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            dsr_q      <= dsr_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            is_div_q   <= is_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.ALUControl = alu_ctrl_c;
    assign bus.illegal    = bus.op_valid & ~legal_c;
    assign bus.stall      = bus.op_valid & hilo_class_c & (busy_q | (state_q != S_IDLE));
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.hilo_rdata = hilo_rdata_c;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: directed test-plan cases plus randomized traffic
// against a transaction-level model (plain integer arithmetic, latency as a cycle countdown).
module tb_alu_muldiv_ctrl;
    localparam int W = 32;
`ifdef ALU_EARLY_OUT_EN
    localparam int EARLY_BUSY = 1;
`else
    localparam int EARLY_BUSY = W + 1;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    alu_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode: returns {unrecognised, alu_code}
    function automatic logic [4:0] exp_dec(input logic [3:0] op, input logic [5:0] f);
        if (op == 4'hF) begin
            case (f)
                6'd32: return 5'b0_0001;
                6'd34: return 5'b0_0010;
                6'd36: return 5'b0_1010;
                6'd37: return 5'b0_1011;
                6'd38: return 5'b0_1100;
                6'd39: return 5'b0_1101;
                6'd42, 6'd43: return 5'b0_0111;
                6'd0:  return 5'b0_0011;
                6'd2:  return 5'b0_0100;
                6'd3:  return 5'b0_0110;
                6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: return 5'b0_0000;
                default: return 5'b1_0000;
            endcase
        end
        case (op)
            4'h1: return 5'b0_0001;
            4'h2: return 5'b0_1010;
            4'h3: return 5'b0_1011;
            4'h4: return 5'b0_1100;
            4'h5, 4'h6: return 5'b0_0010;
            4'h7, 4'h8: return 5'b0_0111;
            4'h9, 4'hC, 4'hD: return 5'b0_0000;
            4'hA, 4'hB: return 5'b0_0001;
            default: return 5'b1_0000;
        endcase
    endfunction

    // Reference mul/div result using 64-bit integer arithmetic
    task automatic calc(input logic [5:0] f, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output logic dz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(xa);
        sb = $signed(xb);
        ua = 64'(xa);
        ub = 64'(xb);
        dz = 1'b0;
        rh = '0;
        rl = '0;
        if (f == 6'd24) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else if (f == 6'd25) begin
            p  = ua * ub;
            rh = p[63:32];
            rl = p[31:0];
        end else if (xb == '0) begin
            dz = 1'b1;
            rl = '1;
            rh = xa;
        end else if (f == 6'd26) begin
            q  = sa / sb;
            r  = sa % sb;
            rl = W'(q);
            rh = W'(r);
        end else begin
            rl = W'(ua / ub);
            rh = W'(ua % ub);
        end
    endtask

    int         m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic       p_dz = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    bit         was_idle;
    bit         early;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
        end else begin
            was_idle = (m_left == 0);
            m_done   = 1'b0;
            m_dz     = 1'b0;
            if (!was_idle) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                    m_dz   = p_dz;
                end
            end else if (bus.op_valid && bus.ALUOp == 4'hF) begin
                if (bus.funct == 6'd17) m_hi = bus.a;
                else if (bus.funct == 6'd19) m_lo = bus.a;
                else if (bus.funct inside {6'd24, 6'd25, 6'd26, 6'd27}) begin
                    calc(bus.funct, bus.a, bus.b, p_hi, p_lo, p_dz);
                    early = 1'b0;
`ifdef ALU_EARLY_OUT_EN
                    early = (bus.funct inside {6'd24, 6'd25}) ? (bus.a == '0 || bus.b == '0)
                                                              : (bus.b == '0);
`endif
                    m_left = early ? 1 : W + 1;
                end
            end
        end
    end

    logic [4:0]   e_dec;
    logic         e_hl, e_rt;
    logic [W-1:0] e_rd;
    bit           cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_dec = exp_dec(bus.ALUOp, bus.funct);
            e_rt  = bus.op_valid && (bus.ALUOp == 4'hF);
            e_hl  = (bus.ALUOp == 4'hF) && (bus.funct inside {6'd16, 6'd17, 6'd18, 6'd19,
                                                             6'd24, 6'd25, 6'd26, 6'd27});
            e_rd  = (e_rt && bus.funct == 6'd16) ? m_hi :
                    (e_rt && bus.funct == 6'd18) ? m_lo : '0;
            chk("alu_control", 64'(bus.ALUControl), 64'(e_dec[3:0]));
            chk("illegal", 64'(bus.illegal), 64'(bus.op_valid & e_dec[4]));
            chk("stall", 64'(bus.stall), 64'(bus.op_valid && e_hl && m_left != 0));
            chk("busy", 64'(bus.busy), 64'(m_left != 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("div_zero", 64'(bus.div_zero), 64'(m_dz));
            chk("hi", 64'(bus.hi), 64'(m_hi));
            chk("lo", 64'(bus.lo), 64'(m_lo));
            chk("hilo_rdata", 64'(bus.hilo_rdata), 64'(e_rd));
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f,
                         input logic [W-1:0] xa, input logic [W-1:0] xb);
        bus.op_valid = v;
        bus.ALUOp    = op;
        bus.funct    = f;
        bus.a        = xa;
        bus.b        = xb;
    endtask

    task automatic wait_done(output int busy_cyc, output bit got, output logic dzs);
        busy_cyc = 0;
        got      = 1'b0;
        dzs      = 1'b0;
        for (int i = 0; i < W + 8 && !got; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                got = 1'b1;
                dzs = bus.div_zero;
            end
        end
    endtask

    // Issue one mul/div for a single accept edge, then wait for its done pulse
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          output int busy_cyc, output bit got, output logic dzs);
        @(posedge clk); #1;
        drive(1'b1, 4'hF, f, xa, xb);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        wait_done(busy_cyc, got, dzs);
    endtask

    function automatic logic [W-1:0] rval();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 20));
            5: return -W'($urandom_range(1, 20));
            default: return W'($urandom());
        endcase
    endfunction

    logic [5:0] fpool [14] = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd17, 6'd18, 6'd19,
                               6'd32, 6'd34, 6'd0, 6'd42, 6'd63, 6'd5};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc, stall_cyc, nd;
        bit   got;
        logic dzs;

        rst_n = 1'b0;
        drive(1'b0, 4'h0, 6'd0, '0, '0);
        #2 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(bus.hi), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        rst_n = 1'b1;

        // MULT -3*5 with MFLO held valid behind it
        @(posedge clk); #1;
        drive(1'b1, 4'hF, 6'd24, 32'hFFFF_FFFD, 32'd5);
        @(posedge clk); #1;
        bus.funct = 6'd18;
        bc = 0; stall_cyc = 0; got = 1'b0;
        for (int i = 0; i < W + 8 && !got; i++) begin
            @(negedge clk);
            if (bus.busy) bc++;
            if (bus.done) begin
                got = 1'b1;
                chk("mflo_stall_in_done", 64'(bus.stall), 64'h0);
                chk("mflo_rdata_new_lo", 64'(bus.hilo_rdata), 64'hFFFF_FFF1);
                chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
                chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);
            end else if (bus.stall) stall_cyc++;
        end
        chk("mult_done_seen", 64'(got), 64'h1);
        chk("mult_busy_cycles", 64'(bc), 64'd33);
        chk("mflo_stall_cycles", 64'(stall_cyc), 64'd33);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;

        run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, got, dzs);
        chk("multu_done_seen", 64'(got), 64'h1);
        chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus.lo), 64'h0000_0001);

        // DIV -7/2 with an ADD decoded while the engine is busy
        @(posedge clk); #1;
        drive(1'b1, 4'hF, 6'd26, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk); #1;
        drive(1'b1, 4'hF, 6'd32, 32'd1, 32'd2);
        @(negedge clk);
        chk("add_busy_ctrl", 64'(bus.ALUControl), 64'h1);
        chk("add_busy_stall", 64'(bus.stall), 64'h0);
        chk("add_busy_busy", 64'(bus.busy), 64'h1);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        wait_done(bc, got, dzs);
        chk("div_done_seen", 64'(got), 64'h1);
        chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, bc, got, dzs);
        chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus.hi), 64'h0);

        run_op(6'd24, 32'd0, 32'd5, bc, got, dzs);
        chk("mult_zero_busy", 64'(bc), 64'(EARLY_BUSY));
        chk("mult_zero_lo", 64'(bus.lo), 64'h0);

        run_op(6'd27, 32'd7, 32'd0, bc, got, dzs);
        chk("divu0_done_seen", 64'(got), 64'h1);
        chk("divu0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(bus.hi), 64'h7);
        chk("divu0_div_zero", 64'(dzs), 64'h1);
        chk("divu0_busy", 64'(bc), 64'(EARLY_BUSY));

        // Reset in the middle of a DIV: no done pulse may ever follow
        @(posedge clk); #1;
        drive(1'b1, 4'hF, 6'd26, 32'd100, 32'd3);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'h0);
        chk("abort_hi", 64'(bus.hi), 64'h0);
        chk("abort_lo", 64'(bus.lo), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'h0);

        @(posedge clk); #1;
        drive(1'b1, 4'hF, 6'd17, 32'h1234, 32'd0);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'h1234);

        drive(1'b1, 4'hF, 6'd63, 32'd0, 32'd0);
        #1;
        chk("funct63_illegal", 64'(bus.illegal), 64'h1);
        chk("funct63_ctrl", 64'(bus.ALUControl), 64'h0);
        @(posedge clk); #1;
        drive(1'b1, 4'h2, 6'd0, 32'd0, 32'd0);
        #1;
        chk("aluop2_ctrl", 64'(bus.ALUControl), 64'hA);
        chk("aluop2_illegal", 64'(bus.illegal), 64'h0);

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            bus.op_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) begin
                bus.ALUOp = 4'hF;
                bus.funct = fpool[$urandom_range(0, 13)];
            end else begin
                bus.ALUOp = 4'($urandom_range(0, 15));
                bus.funct = 6'($urandom_range(0, 63));
            end
            bus.a = rval();
            bus.b = rval();
        end

        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        for (int i = 0; i < W + 8 && m_left != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
